// File: rtl/alu_ctrl_pkg.sv
// Shared types and instruction layout for the ALU instruction controller.
package alu_ctrl_pkg;

  localparam int unsigned REG_N   = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned INSTR_W = 9;

  localparam int unsigned OPC_HI  = 8;
  localparam int unsigned OPC_LO  = 6;
  localparam int unsigned DST_HI  = 5;
  localparam int unsigned DST_LO  = 4;
  localparam int unsigned SRCA_HI = 3;
  localparam int unsigned SRCA_LO = 2;
  localparam int unsigned SRCB_HI = 1;
  localparam int unsigned SRCB_LO = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_LDI  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

  function automatic logic is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic uses_alu(input logic [2:0] op);
    return !is_illegal(op) && (op != OP_LDI);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by alu_ctrl; results are RES_W wide, SUB wraps, MUL truncates.
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned RES_W  = DATA_W + 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [RES_W-1:0]  result
);

  logic [2*DATA_W-1:0] prod;

  always_comb begin
    prod   = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    result = '0;
    case (opcode_e'(opcode))
      OP_ADD:  result = RES_W'(a) + RES_W'(b);
      OP_SUB:  result = RES_W'(a) - RES_W'(b);
      OP_MUL:  result = prod[RES_W-1:0];
      OP_AND:  result = RES_W'(a & b);
      OP_OR:   result = RES_W'(a | b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_regfile.sv
// REG_N x DATA_W register file: one synchronous write port, two operand reads and a debug read.
module alu_regfile
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rf [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) rf[i] <= '0;
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  always_comb begin
    ra_data = rf[ra_addr];
    rb_data = rf[rb_addr];
    rd_data = rf[rd_addr];
  end

endmodule

// File: rtl/alu_ctrl.sv
// Fetch/decode/execute/write-back sequencer in front of the external combinational ALU.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned RES_W  = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [8:0]        in_instr,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [RES_W-1:0]  alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic [1:0]        out_dst,
  output logic              out_err,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_e               state;
  logic [INSTR_W-1:0]   instr;
  logic [2:0]           opc;
  logic [ADDR_W-1:0]    dst;
  logic [DATA_W-1:0]    imm;
  logic [DATA_W-1:0]    ra_data;
  logic [DATA_W-1:0]    rb_data;
  logic                 rf_we;
  logic [DATA_W-1:0]    rf_wdata;

  always_comb begin
    opc      = instr[OPC_HI:OPC_LO];
    dst      = instr[DST_HI:DST_LO];
    imm      = DATA_W'(instr[SRCB_HI:SRCB_LO]);
    in_ready = (state == ST_IDLE);
    // Write-back happens on the EXEC edge, so the next DECODE always sees it.
    rf_we    = (state == ST_EXEC) && !is_illegal(opc);
    rf_wdata = (opc == OP_LDI) ? imm : alu_result[DATA_W-1:0];
  end

  alu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (dst),
    .wdata   (rf_wdata),
    .ra_addr (instr[SRCA_HI:SRCA_LO]),
    .ra_data (ra_data),
    .rb_addr (instr[SRCB_HI:SRCB_LO]),
    .rb_data (rb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      instr     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dst   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            instr <= in_instr;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (uses_alu(opc)) begin
            alu_a  <= ra_data;
            alu_b  <= rb_data;
            alu_op <= opc;
          end
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          out_valid <= 1'b1;
          out_dst   <= dst;
          if (is_illegal(opc)) begin
            out_data <= '0;
            out_err  <= 1'b1;
          end else if (opc == OP_LDI) begin
            out_data <= RES_W'(imm);
            out_err  <= 1'b0;
          end else begin
            out_data <= alu_result;
            out_err  <= 1'b0;
          end
          state <= ST_WB;
        end
        ST_WB: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: reference register model, queued expectations, separate monitor.
module tb_alu_ctrl;

  localparam int unsigned DW = 2;
  localparam int unsigned RW = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [8:0]    in_instr = '0;
  logic          in_ready;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [RW-1:0] alu_result;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_data;
  logic [1:0]    out_dst;
  logic          out_err;
  logic [1:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  alu #(.DATA_W(DW), .RES_W(RW)) u_alu (
    .a(alu_a), .b(alu_b), .opcode(alu_op), .result(alu_result)
  );

  alu_ctrl #(.DATA_W(DW), .RES_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dst(out_dst), .out_err(out_err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct {
    int data;
    int dst;
    int err;
  } exp_t;

  exp_t sbq[$];
  int   rf_m[4];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference semantics: plain integer arithmetic modulo the result/register widths.
  task automatic model(input logic [8:0] ins, output exp_t e);
    int op, a, b, r, m;
    m  = 1 << RW;
    op = int'(ins[8:6]);
    a  = rf_m[ins[3:2]];
    b  = rf_m[ins[1:0]];
    e.err = 0;
    case (op)
      0: r = (a + b) % m;
      1: r = (a - b + m) % m;
      2: r = (a * b) % m;
      3: r = a & b;
      4: r = a | b;
      5: r = int'(ins[1:0]) % (1 << DW);
      default: begin r = 0; e.err = 1; end
    endcase
    e.data = r;
    e.dst  = int'(ins[5:4]);
    if (e.err == 0) rf_m[ins[5:4]] = r % (1 << DW);
  endtask

  task automatic check_rf(input string nm);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk(nm, int'(rd_data), rf_m[i]);
    end
  endtask

  // Monitor: compares each completion at the cycle it is handed downstream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_data", int'(out_data), e.data);
          chk("out_dst",  int'(out_dst),  e.dst);
          chk("out_err",  int'(out_err),  e.err);
        end
      end
    end
  end

  task automatic issue(input logic [8:0] ins, input int stall, input logic lat_chk);
    exp_t e;
    int   cnt;
    logic [RW-1:0] held;
    @(negedge clk);
    cnt = 0;
    while (!in_ready && cnt < 20) begin @(negedge clk); cnt++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid  = 1'b1;
    in_instr  = ins;
    out_ready = (stall == 0);
    model(ins, e);
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 12) begin @(negedge clk); cnt++; end
    if (lat_chk) chk("latency", cnt, 3);
    else if (!out_valid) chk("out_valid_timeout", 0, 1);
    held = out_data;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_instr = 9'($urandom_range(0, 511));
      #1;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data",  int'(out_data), int'(held));
      chk("stall_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    if (stall > 0) chk("released", int'(out_valid), 0);
    check_rf("rf");
  endtask

  function automatic logic [8:0] mk(input int op, input int d, input int sa, input int sb);
    return {3'(op), 2'(d), 2'(sa), 2'(sb)};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) rf_m[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    check_rf("reset_rf");

    issue(mk(5, 1, 0, 3), 0, 1);   // LDI r1,3
    issue(mk(5, 2, 0, 2), 0, 1);   // LDI r2,2
    issue(mk(0, 0, 1, 2), 0, 1);   // ADD r0,r1,r2 -> 5
    issue(mk(1, 3, 2, 1), 0, 1);   // SUB r3,r2,r1 -> 7
    issue(mk(2, 0, 1, 2), 0, 1);   // MUL r0,r1,r2 -> 6
    issue(mk(3, 2, 1, 3), 5, 1);   // AND under backpressure
    issue(mk(6, 1, 2, 3), 0, 1);   // illegal 110
    issue(mk(7, 3, 0, 0), 2, 1);   // illegal 111
    issue(mk(4, 0, 2, 3), 0, 1);   // OR

    for (int k = 0; k < 40; k++)
      issue(9'($urandom_range(0, 511)), int'($urandom_range(0, 3)), 1'b1);

    // Reset while an ADD sits in EXEC: nothing may complete or be written back.
    @(negedge clk);
    in_valid  = 1'b1;
    in_instr  = mk(0, 3, 1, 2);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) rf_m[i] = 0;
    chk("rst_exec_out_valid", int'(out_valid), 0);
    chk("rst_exec_in_ready", int'(in_ready), 1);
    check_rf("rst_exec_rf");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_out_valid", int'(out_valid), 0);
    end
    check_rf("post_rst_rf");
    issue(mk(5, 2, 0, 1), 0, 1);
    issue(mk(0, 1, 2, 2), 1, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Multi-cycle instruction controller that drives the team's combinational `alu` block. It accepts 9-bit instructions over a valid/ready handshake and decodes them. It reads operands from a 4-entry register file, presents `a`/`b`/`opcode` to the external ALU, and captures the ALU result. It then writes the result back and offers it downstream with backpressure. It is the fetch/decode/execute/write-back sequencer that sits in front of the ALU datapath.

## Interface
- `DATA_W`, 2, operand/register width; must match ALU `a`/`b` width.
- `RES_W`, `DATA_W+1`, ALU result width; must match ALU `result` width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  instruction valid.
- `in_instr`  in  9  instruction fields: [8:6] opcode, [5:4] dst, [3:2] srcA, [1:0] srcB.
- `in_ready`  out  1  controller can accept an instruction.
- `alu_a`  out  DATA_W  operand A to ALU.
- `alu_b`  out  DATA_W  operand B to ALU.
- `alu_op`  out  3  opcode to ALU.
- `alu_result`  in  RES_W  combinational ALU result.
- `out_valid`  out  1  completion record valid.
- `out_ready`  in  1  downstream accepts completion.
- `out_data`  out  RES_W  full-width result (0 on error).
- `out_dst`  out  2  destination register of completed instruction.
- `out_err`  out  1  illegal opcode flag.
- `rd_addr`  in  2  debug read address.
- `rd_data`  out  DATA_W  combinational read of `rf[rd_addr]`.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR (forwarded to ALU); 101 LDI: `rf[dst] = srcB` field zero-extended/truncated to DATA_W, no ALU use; 110/111 illegal.
- FSM states IDLE, DECODE, EXEC, WB.
- IDLE: `in_ready=1`; on `in_valid&&in_ready` latch instr → DECODE.
- DECODE: register `alu_a=rf[srcA]`, `alu_b=rf[srcB]`, `alu_op=opcode` (LDI/illegal: ALU outputs unchanged) → EXEC.
- EXEC: capture `alu_result` (LDI: imm zero-extended to RES_W; illegal: 0, err=1) into output regs; write `rf[dst]` with low DATA_W bits unless illegal; set `out_valid` → WB.
- WB: hold all outputs stable while `out_ready=0`; on `out_ready=1` clear `out_valid` → IDLE.
- SUB wraps modulo 2^RES_W; MUL truncated to RES_W; writeback truncates to DATA_W; no overflow flag.
- `in_valid` outside IDLE ignored; no queueing.
- Reset: state IDLE, rf all 0, `alu_a/alu_b/alu_op/out_data/out_dst/out_err/out_valid` = 0, `in_ready`=1 (IDLE decode), instruction in flight discarded.

## Timing
- Accept at edge N; DECODE cycle N..N+1; ALU sampled at edge N+2; `out_valid` high after edge N+2, rf updated same edge.
- Minimum 3 cycles from acceptance to `out_valid`; throughput one instruction per 4 cycles with `out_ready` tied high.
- `rd_data` reflects write one cycle after the EXEC edge (no bypass).
- Back-to-back dependent instructions always see prior writeback (rf written before next DECODE).
- `out_ready` high while `out_valid` low has no effect.

## Structure
- `alu_ctrl_pkg`: opcode enum (`OP_ADD..OP_LDI`), state enum, instruction field bit positions, `REG_N=4`.
- Sub-module `alu_regfile`: 4×DATA_W, one sync write port, two comb read ports plus debug read, async active-low clear.
- ALU stays external; the testbench instantiates `alu` and connects it to the `alu_*` ports.

## Test plan
- Reset: after `rst_n` rises, `in_ready=1`, `out_valid=0`, `rd_data=0` for all addresses.
- LDI r1,3; LDI r2,2; ADD r0,r1,r2 → `out_data=3'b101`, `out_dst=0`, `rf[0]=2'b01`, `out_valid` 3 cycles after acceptance.
- SUB r3,r2,r1 (2−3) → `out_data=3'b111`, `rf[3]=2'b11`; MUL r0,r1,r2 → `out_data=3'b110`, `rf[0]=2'b10`.
- Backpressure: `out_ready=0` for 5 cycles → `out_valid`/`out_data` stable, `in_ready=0`, `in_valid` pulses ignored; completes on `out_ready=1`.
- Illegal opcode 110 → `out_err=1`, `out_data=0`, rf unchanged, returns to IDLE.
- `rst_n` low during EXEC → immediately IDLE, `out_valid=0`, rf cleared, no writeback.
